// File: rtl/rgbw_pwm_bank.sv
// rgbw_pwm_bank
// CHANNELS x WIDTH PWM generator for the RGBW lamp controller. Each channel
// has a duty shadow register. A global brightness register scales every duty
// on one shared shift-add multiplier, and the scaled duties go live together
// at the PWM period wrap.
//
// Optional feature: define PWM_PHASE_STAGGER_EN to give channel i a compare
// phase offset of i*(2^WIDTH/CHANNELS). This spreads the rising edges across
// the period. With the macro undefined, every channel rises at cnt=0.
//
// CHANNELS*(WIDTH+1) must be less than PRESC*2^WIDTH, so that scaling always
// finishes inside one period. If a wrap arrives while scaling is still running,
// that wrap is ignored: nothing is committed and no snapshot is taken.
module rgbw_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC    = 2,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                busy
);

  localparam int PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW     = $clog2(WIDTH + 1);
  localparam int PROD_W = 2 * WIDTH + 1;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int PHASE_STEP = (2 ** WIDTH) / CHANNELS;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Timebase
  logic [PW-1:0]       presc_r;
  logic [WIDTH-1:0]    cnt_r;
  logic                tick_s;
  logic                wrap_s;

  // Register file and duty pipeline
  logic [WIDTH-1:0]    shadow_r      [CHANNELS];
  logic [WIDTH-1:0]    shadow_next_s [CHANNELS];
  logic [WIDTH-1:0]    bright_r;
  logic [WIDTH-1:0]    bright_next_s;
  logic [WIDTH-1:0]    snap_r        [CHANNELS];
  logic [WIDTH-1:0]    snap_bright_r;
  logic [WIDTH-1:0]    staged_r      [CHANNELS];
  logic [WIDTH-1:0]    active_r      [CHANNELS];

  // Scaler sequencer and datapath
  state_t              state_r;
  state_t              next_state_s;
  logic [CW-1:0]       ch_r;
  logic [SW-1:0]       step_r;
  logic [PROD_W-1:0]   acc_r;
  logic [PROD_W-1:0]   mcand_r;
  logic [WIDTH-1:0]    mplier_r;
  logic [PROD_W-1:0]   acc_sum_s;
  logic                last_step_s;
  logic                last_ch_s;
  logic                snap_take_s;
  logic                commit_s;
  logic                busy_next_s;

  // Compare and outputs
  logic [WIDTH-1:0]    phase_s [CHANNELS];
  logic [CHANNELS-1:0] pwm_next_s;
  logic [CHANNELS-1:0] pwm_r;
  logic                period_tick_r;
  logic                busy_r;

  assign tick_s      = en && (presc_r == PW'(PRESC - 1));
  assign wrap_s      = tick_s && (cnt_r == {WIDTH{1'b1}});
  assign last_step_s = (step_r == SW'(WIDTH));
  assign last_ch_s   = (ch_r == CW'(CHANNELS - 1));
  assign acc_sum_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  assign pwm_out     = pwm_r;
  assign period_tick = period_tick_r;
  assign busy        = busy_r;

  // Prescaler: divide clk down to PWM ticks while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else if (en) begin
      presc_r <= presc_r + PW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // PWM counter: advance once per tick; the all-ones tick is the period wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Write decode: the next shadow and brightness values, including this cycle's write
  always_comb begin
    shadow_next_s = shadow_r;
    bright_next_s = bright_r;
    if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          shadow_next_s[i] = wr_data;
        end else begin
          shadow_next_s[i] = shadow_r[i];
        end
      end
      if (wr_addr == ADDR_W'(CHANNELS)) begin
        bright_next_s = wr_data;
      end else begin
        bright_next_s = bright_r;
      end
    end else begin
      shadow_next_s = shadow_r;
      bright_next_s = bright_r;
    end
  end

  // Shadow and brightness registers: immediate host writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= '0;
      end
      bright_r <= {WIDTH{1'b1}};
    end else begin
      shadow_r <= shadow_next_s;
      bright_r <= bright_next_s;
    end
  end

  // Snapshot: freeze the scaler inputs at a wrap; a write in the same cycle is included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        snap_r[i] <= '0;
      end
      snap_bright_r <= {WIDTH{1'b1}};
    end else if (snap_take_s) begin
      snap_r        <= shadow_next_s;
      snap_bright_r <= bright_next_s;
    end else begin
      snap_r        <= snap_r;
      snap_bright_r <= snap_bright_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: a wrap starts scaling; the last bit of the last channel finishes it
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: next_state_s = wrap_s ? ST_MUL : ST_IDLE;
      ST_MUL:  next_state_s = (last_step_s && last_ch_s) ? ST_DONE : ST_MUL;
      ST_DONE: next_state_s = wrap_s ? ST_MUL : ST_DONE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: snapshot, commit and busy controls; a wrap during MUL does nothing
  always_comb begin
    snap_take_s = 1'b0;
    commit_s    = 1'b0;
    busy_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        snap_take_s = wrap_s;
        busy_next_s = wrap_s;
      end
      ST_MUL: begin
        busy_next_s = !(last_step_s && last_ch_s);
      end
      ST_DONE: begin
        snap_take_s = wrap_s;
        commit_s    = wrap_s;
        busy_next_s = wrap_s;
      end
      default: begin
        snap_take_s = 1'b0;
        commit_s    = 1'b0;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Scaler sequencer: step 0 loads the operands, steps 1..WIDTH each consume one multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r <= '0;
      ch_r   <= '0;
    end else if (snap_take_s) begin
      step_r <= '0;
      ch_r   <= '0;
    end else if (state_r == ST_MUL) begin
      if (last_step_s) begin
        step_r <= '0;
        ch_r   <= last_ch_s ? CW'(0) : (ch_r + CW'(1));
      end else begin
        step_r <= step_r + SW'(1);
        ch_r   <= ch_r;
      end
    end else begin
      step_r <= step_r;
      ch_r   <= ch_r;
    end
  end

  // Shift-add datapath: duty * (brightness + 1), LSB of the duty first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (state_r == ST_MUL) begin
      if (step_r == SW'(0)) begin
        acc_r    <= '0;
        mcand_r  <= PROD_W'(snap_bright_r) + PROD_W'(1);
        mplier_r <= snap_r[ch_r];
      end else begin
        acc_r    <= acc_sum_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
      end
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  // Staged duties: keep the top half of each finished product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        staged_r[i] <= '0;
      end
    end else if ((state_r == ST_MUL) && last_step_s) begin
      staged_r[ch_r] <= acc_sum_s[WIDTH +: WIDTH];
    end else begin
      staged_r <= staged_r;
    end
  end

  // Active duties: all channels switch together at a committing wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active_r[i] <= '0;
      end
    end else if (commit_s) begin
      active_r <= staged_r;
    end else begin
      active_r <= active_r;
    end
  end

  // Per-channel compare phase and next PWM level
  always_comb begin
    phase_s    = '{default: '0};
    pwm_next_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
      phase_s[i] = cnt_r + WIDTH'(i * PHASE_STEP);
`else
      phase_s[i] = cnt_r;
`endif
      pwm_next_s[i] = (phase_s[i] < active_r[i]);
    end
  end

  // Registered outputs: pwm_out holds while disabled; period_tick and busy mirror their events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r         <= '0;
      period_tick_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (en) begin
        pwm_r <= pwm_next_s;
      end else begin
        pwm_r <= pwm_r;
      end
      period_tick_r <= wrap_s;
      busy_r        <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_rgbw_pwm_bank.sv
// tb_rgbw_pwm_bank
// Directed and randomised stimulus for rgbw_pwm_bank. The reference model works
// from the behavioural rules: the duty registers, a snapshot at each wrap, a
// commit at the following wrap, and an arithmetic PWM level for each counter value.
// Honours PWM_PHASE_STAGGER_EN in the same way as the design.
`timescale 1ns/1ps
module tb_rgbw_pwm_bank;

  localparam int CH     = 4;
  localparam int W      = 8;
  localparam int PR     = 2;
  localparam int AW     = 3;
  localparam int FULL   = 1 << W;
  localparam int PERIOD = PR * FULL;
  localparam int SCALE_CLKS = CH * (W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          busy;

  rgbw_pwm_bank #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .PRESC   (PR),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_shadow [CH];
  int m_bright;
  int m_snap   [CH];
  int m_snap_b;
  bit m_snap_valid;
  int m_act    [CH];
  int last_hi  [CH];

  typedef struct {
    int j;
    int a;
    int d;
  } wr_t;
  wr_t wq[$];

  function automatic int scale(input int d, input int b);
    return (d * (b + 1)) / FULL;
  endfunction

  function automatic int offset(input int k);
`ifdef PWM_PHASE_STAGGER_EN
    return k * (FULL / CH);
`else
    return 0 * k;
`endif
  endfunction

  function automatic bit exp_bit(input int k, input int c);
    return ((c + offset(k)) % FULL) < m_act[k];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_shadow[k] = 0;
      m_snap[k]   = 0;
      m_act[k]    = 0;
    end
    m_bright     = FULL - 1;
    m_snap_b     = FULL - 1;
    m_snap_valid = 1'b0;
  endtask

  task automatic model_wrap();
    if (m_snap_valid) begin
      for (int k = 0; k < CH; k++) m_act[k] = scale(m_snap[k], m_snap_b);
    end
    for (int k = 0; k < CH; k++) m_snap[k] = m_shadow[k];
    m_snap_b     = m_bright;
    m_snap_valid = 1'b1;
  endtask

  // Drive a one-cycle write (cleared at the next negedge) and apply it to the model
  task automatic set_write(input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av      = a;
    dv      = d;
    wr_en   = 1'b1;
    wr_addr = av[AW-1:0];
    wr_data = dv[W-1:0];
    if (a < CH) m_shadow[a] = d;
    else if (a == CH) m_bright = d;
  endtask

  // After a reset release: wait (bounded) for the first wrap, which only snapshots
  task automatic wait_first_wrap();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
    end while (period_tick !== 1'b1 && n < 4 * PERIOD);
    check("first_wrap_delay", n, PERIOD);
    check("first_wrap_busy", 32'(busy), 1);
    model_wrap();
  endtask

  // One PWM period. It starts at the negedge that shows period_tick and ends at
  // the next one. fz >= 0 freezes en for 1000 cycles after sample fz.
  task automatic run_period(input int fz, input bit chk_rise, input bit rnd);
    int hi [CH];
    int bad [CH];
    int first [CH];
    int a0 [CH];
    int busy_n;
    int tick_n;
    int frz_bad;
    int c;
    logic b;
    busy_n  = 0;
    tick_n  = 0;
    frz_bad = 0;
    for (int k = 0; k < CH; k++) begin
      hi[k] = 0; bad[k] = 0; first[k] = -1; a0[k] = m_act[k];
    end
    for (int j = 0; j < PERIOD; j++) begin
      @(negedge clk);
      wr_en = 1'b0;
      c = j / PR;
      for (int k = 0; k < CH; k++) begin
        b = pwm_out[k];
        if (b !== exp_bit(k, c)) bad[k]++;
        if (b === 1'b1) begin
          hi[k]++;
          if (first[k] < 0) first[k] = j;
        end
      end
      if (j < PERIOD - 1) begin
        if (busy === 1'b1) busy_n++;
        if (period_tick !== 1'b0) tick_n++;
      end else begin
        check("period_tick_at_wrap", 32'(period_tick), 1);
        check("busy_at_wrap", 32'(busy), 1);
        model_wrap();
      end
      if (wq.size() > 0 && wq[0].j == j) begin
        set_write(wq[0].a, wq[0].d);
        void'(wq.pop_front());
      end else if (rnd && $urandom_range(31, 0) == 0) begin
        set_write(int'($urandom_range(7, 0)), int'($urandom_range(FULL - 1, 0)));
      end
      if (j == fz) begin
        en = 1'b0;
        for (int f = 0; f < 1000; f++) begin
          @(negedge clk);
          wr_en = 1'b0;
          for (int k = 0; k < CH; k++) begin
            if (pwm_out[k] !== exp_bit(k, c)) frz_bad++;
          end
          if (busy === 1'b1) busy_n++;
          if (period_tick !== 1'b0) tick_n++;
        end
        check("freeze_busy_done", 32'(busy), 0);
        en = 1'b1;
      end
    end
    for (int k = 0; k < CH; k++) begin
      check($sformatf("pwm_shape_ch%0d", k), bad[k], 0);
      check($sformatf("pwm_duty_ch%0d", k), hi[k], a0[k] * PR);
      last_hi[k] = hi[k];
      if (chk_rise) check($sformatf("rise_pos_ch%0d", k), first[k], PR * ((FULL - offset(k)) % FULL));
    end
    check("busy_length", busy_n, SCALE_CLKS - 1);
    check("no_extra_tick", tick_n, 0);
    if (fz >= 0) check("freeze_hold", frz_bad, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_tick", 32'(period_tick), 0);
    check("rst_busy", 32'(busy), 0);

    rst_n = 1'b1;
    en    = 1'b1;
    set_write(0, 64);
    wait_first_wrap();
    run_period(-1, 1'b0, 1'b0);                // P1: nothing committed yet
    run_period(-1, 1'b0, 1'b0);                // P2: duty 64 live
    check("duty64_high_clocks", last_hi[0], 128);

    wq.push_back('{100, 1, 200});
    wq.push_back('{101, CH, 127});
    wq.push_back('{102, 2, 255});
    run_period(-1, 1'b0, 1'b0);                // P3: writes captured at the next wrap
    wq.push_back('{200, CH, 0});
    run_period(-1, 1'b0, 1'b0);                // P4
    run_period(-1, 1'b0, 1'b0);                // P5: bright 127 applied
    check("scale_200x127", last_hi[1], 200);
    check("scale_64x127", last_hi[0], 64);
    wq.push_back('{50, CH, 255});
    wq.push_back('{PERIOD - 2, 3, 10});        // coincident with the wrap
    wq.push_back('{PERIOD - 1, 3, 20});        // one cycle after the wrap
    run_period(-1, 1'b0, 1'b0);                // P6
    run_period(-1, 1'b0, 1'b0);                // P7: bright 0 applied
    check("bright0_ch2_low", last_hi[2], 0);
    run_period(-1, 1'b0, 1'b0);                // P8
    check("wrap_write_10", last_hi[3], 20);
    run_period(10, 1'b0, 1'b0);                // P9: en low for 1000 cycles, scaler mid-run
    check("post_wrap_write_20", last_hi[3], 40);

    // Reset in the middle of a scaling run
    repeat (5) @(negedge clk);
    check("busy_before_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pwm", 32'(pwm_out), 0);
    check("midrst_tick", 32'(period_tick), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_write(0, 128);
    wait_first_wrap();
    run_period(-1, 1'b0, 1'b0);
    run_period(-1, 1'b0, 1'b0);
    check("reset_bright_default", last_hi[0], 256);

    // Randomised writes, including unused addresses
    for (int r = 0; r < 6; r++) run_period(-1, 1'b0, 1'b1);

    // Phase placement with all duties at 64
    for (int k = 0; k < CH; k++) wq.push_back('{k, k, 64});
    wq.push_back('{CH, CH, 255});
    run_period(-1, 1'b0, 1'b0);
    run_period(-1, 1'b0, 1'b0);
    run_period(-1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
